// File: rtl/psa_search_engine_pkg.sv
// Shared types and constants for the PSA pattern-search engine.
// Default widths, FSM state encoding and the mode constants.
package psa_search_engine_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_PADDR_W = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CNT_W   = 8;

  localparam logic MODE_FIRST = 1'b0;
  localparam logic MODE_COUNT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT,
    ST_CMP,
    ST_ADV,
    ST_HIT,
    ST_DONE
  } state_e;

  // A new command is only taken when the engine is not walking the block.
  function automatic logic start_allowed(state_e s);
    return (s == ST_IDLE) || (s == ST_HIT) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/psa_search_engine_if.sv
// Command, status and BRAM read-port bundle of the search engine.
// master = host plus BRAM models, slave = the engine.
interface psa_search_engine_if
  import psa_search_engine_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int PADDR_W = DEF_PADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CNT_W   = DEF_CNT_W
);

  logic               start;
  logic               resume;
  logic               mode;
  logic [PADDR_W-1:0] p;
  logic [PADDR_W-1:0] pl;
  logic [ADDR_W-1:0]  b;
  logic [ADDR_W-1:0]  bl;
  logic               wc_en;
  logic [DATA_W-1:0]  wc_val;

  logic [PADDR_W-1:0] addra_p;
  logic [DATA_W-1:0]  douta_p;
  logic [ADDR_W-1:0]  addra;
  logic [DATA_W-1:0]  douta;

  logic               busy;
  logic               hit;
  logic [ADDR_W-1:0]  found;
  logic [CNT_W-1:0]   match_count;
  logic               done;

  modport master (
    output start, resume, mode, p, pl, b, bl, wc_en, wc_val,
    output douta_p, douta,
    input  addra_p, addra,
    input  busy, hit, found, match_count, done
  );

  modport slave (
    input  start, resume, mode, p, pl, b, bl, wc_en, wc_val,
    input  douta_p, douta,
    output addra_p, addra,
    output busy, hit, found, match_count, done
  );

endinterface

// File: rtl/psa_search_engine_word_cmp.sv
// Single-word compare: data equals pattern, or the pattern word is the wildcard.
// Purely combinational.
module psa_search_engine_word_cmp #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_dat,
  input  logic [DATA_W-1:0] i_pat,
  input  logic              i_wc_en,
  input  logic [DATA_W-1:0] i_wc_val,
  output logic              o_eq
);

  logic w_exact;
  logic w_wild;

  assign w_exact = (i_dat == i_pat);
  assign w_wild  = i_wc_en && (i_pat == i_wc_val);
  assign o_eq    = w_exact || w_wild;

endmodule

// File: rtl/psa_search_engine.sv
// Naive shift-by-one pattern scan over a data BRAM block; 3 cycles per compared word.
// Modes: stop at each match (resumable) or count all matches to the end of the block.
module psa_search_engine
  import psa_search_engine_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int PADDR_W = DEF_PADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                CLK100MHZ,
  input  logic                reset,
  psa_search_engine_if.slave  bus
);

  localparam int CMP_W = (ADDR_W > PADDR_W) ? ADDR_W : PADDR_W;

  state_e             r_state;
  logic [PADDR_W-1:0] r_p;
  logic [PADDR_W-1:0] r_pl;
  logic [ADDR_W-1:0]  r_b;
  logic [ADDR_W-1:0]  r_bl;
  logic               r_mode;
  logic               r_wc_en;
  logic [DATA_W-1:0]  r_wc_val;

  logic [ADDR_W-1:0]  r_i;
  logic [PADDR_W-1:0] r_j;

  logic [PADDR_W-1:0] r_addra_p;
  logic [ADDR_W-1:0]  r_addra;
  logic               r_busy;
  logic               r_hit;
  logic               r_done;
  logic [ADDR_W-1:0]  r_found;
  logic [CNT_W-1:0]   r_cnt;

  logic w_eq;
  logic w_start_ok;
  logic w_no_scan;
  logic w_last_j;
  logic w_last_i;
  logic w_cnt_full;

  psa_search_engine_word_cmp #(
    .DATA_W (DATA_W)
  ) u_cmp (
    .i_dat    (bus.douta),
    .i_pat    (bus.douta_p),
    .i_wc_en  (r_wc_en),
    .i_wc_val (r_wc_val),
    .o_eq     (w_eq)
  );

  assign w_start_ok = bus.start && start_allowed(r_state);
  // Length compare is done at the wider of the two widths so pl>bl is exact.
  assign w_no_scan  = (r_pl == '0) || (CMP_W'(r_pl) > CMP_W'(r_bl));
  assign w_last_j   = (r_j == (r_pl - PADDR_W'(1)));
  assign w_last_i   = (r_i == (r_bl - ADDR_W'(r_pl)));
  assign w_cnt_full = (r_cnt == {CNT_W{1'b1}});

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_p       <= '0;
      r_pl      <= '0;
      r_b       <= '0;
      r_bl      <= '0;
      r_mode    <= MODE_FIRST;
      r_wc_en   <= 1'b0;
      r_wc_val  <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_addra_p <= '0;
      r_addra   <= '0;
      r_busy    <= 1'b0;
      r_hit     <= 1'b0;
      r_done    <= 1'b0;
      r_found   <= '0;
      r_cnt     <= '0;
    end else if (w_start_ok) begin
      // start outranks a simultaneous resume
      r_state  <= ST_CHECK;
      r_p      <= bus.p;
      r_pl     <= bus.pl;
      r_b      <= bus.b;
      r_bl     <= bus.bl;
      r_mode   <= bus.mode;
      r_wc_en  <= bus.wc_en;
      r_wc_val <= bus.wc_val;
      r_i      <= '0;
      r_j      <= '0;
      r_busy   <= 1'b1;
      r_hit    <= 1'b0;
      r_done   <= 1'b0;
      r_found  <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_IDLE;
        ST_CHECK: begin
          if (w_no_scan) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_addra_p <= r_p + r_j;
          r_addra   <= r_b + r_i + ADDR_W'(r_j);
          r_state   <= ST_WAIT;
        end
        ST_WAIT: r_state <= ST_CMP;
        ST_CMP: begin
          if (!w_eq) begin
            r_state <= ST_ADV;
          end else if (!w_last_j) begin
            r_j     <= r_j + PADDR_W'(1);
            r_state <= ST_ISSUE;
          end else begin
            r_found <= r_i;
            if (!w_cnt_full) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_mode == MODE_FIRST) begin
              r_state <= ST_HIT;
              r_hit   <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_ADV;
            end
          end
        end
        ST_ADV: begin
          r_j <= '0;
          if (w_last_i) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_i     <= r_i + ADDR_W'(1);
            r_state <= ST_ISSUE;
          end
        end
        ST_HIT: begin
          if (bus.resume) begin
            r_state <= ST_ADV;
            r_hit   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_DONE: r_state <= ST_DONE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.addra_p     = r_addra_p;
  assign bus.addra       = r_addra;
  assign bus.busy        = r_busy;
  assign bus.hit         = r_hit;
  assign bus.done        = r_done;
  assign bus.found       = r_found;
  assign bus.match_count = r_cnt;

endmodule

// File: tb/tb_psa_search_engine.sv
// Directed bench for psa_search_engine with 1-cycle-latency BRAM models.
module tb_psa_search_engine;
  import psa_search_engine_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  psa_search_engine_if bus ();

  psa_search_engine dut (
    .CLK100MHZ (clk),
    .reset     (rst),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] dmem [0:255];
  logic [7:0] pmem [0:255];

  always @(posedge clk) begin
    bus.douta   <= dmem[bus.addra];
    bus.douta_p <= pmem[bus.addra_p];
  end

  // Log of every distinct data address presented, plus a count of cycles with hit high.
  logic [7:0] addr_log [0:4095];
  int         addr_n = 0;
  int         hit_n  = 0;
  logic [7:0] last_a = 8'h00;
  always @(posedge clk) begin
    if (bus.addra !== last_a) begin
      addr_log[addr_n % 4096] = bus.addra;
      addr_n = addr_n + 1;
      last_a = bus.addra;
    end
    if (bus.hit === 1'b1) hit_n = hit_n + 1;
  end

  typedef struct {
    logic [7:0]  b;
    logic [7:0]  bl;
    logic [7:0]  pl;
    logic        wc_en;
    logic [31:0] pat;
    logic [7:0]  exp_cnt;
    logic [7:0]  exp_found;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic load_cmd(input logic [7:0] b, input logic [7:0] bl, input logic [7:0] p,
                          input logic [7:0] pl, input logic mode, input logic wc_en,
                          input logic [31:0] pat);
    logic [31:0] t;
    t = pat;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(pl)) pmem[8'(int'(p) + k)] = t[31-8*k -: 8];
    end
    bus.b      = b;
    bus.bl     = bl;
    bus.p      = p;
    bus.pl     = pl;
    bus.mode   = mode;
    bus.wc_en  = wc_en;
    bus.wc_val = 8'h3F;
  endtask

  task automatic pulse(input logic do_start, input logic do_resume);
    @(negedge clk);
    bus.start  = do_start;
    bus.resume = do_resume;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.resume = 1'b0;
  endtask

  task automatic wait_for(input logic want_done, input int budget, output int n);
    string nm;
    nm = want_done ? "wait_done" : "wait_hit";
    n = 0;
    while (((want_done ? bus.done : bus.hit) !== 1'b1) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, 32'(n < budget), 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    int h0;
    load_cmd(v.b, v.bl, 8'h40, v.pl, MODE_COUNT, v.wc_en, v.pat);
    h0 = hit_n;
    pulse(1'b1, 1'b0);
    wait_for(1'b1, 500, n);
    chk($sformatf("v%0d_cnt", idx), 32'(bus.match_count), 32'(v.exp_cnt));
    if (v.exp_cnt != 8'd0) chk($sformatf("v%0d_found", idx), 32'(bus.found), 32'(v.exp_found));
    chk($sformatf("v%0d_nohit", idx), 32'(hit_n - h0), 32'd0);
    chk($sformatf("v%0d_busy", idx), 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int n;
    int s;
    logic seen;

    vecs[0] = '{b: 8'h00, bl: 8'd8, pl: 8'd2, wc_en: 1'b0, pat: 32'h41420000, exp_cnt: 8'd3, exp_found: 8'd6};
    vecs[1] = '{b: 8'h10, bl: 8'd6, pl: 8'd3, wc_en: 1'b1, pat: 32'h413F4300, exp_cnt: 8'd2, exp_found: 8'd3};
    vecs[2] = '{b: 8'h00, bl: 8'd8, pl: 8'd2, wc_en: 1'b0, pat: 32'h42430000, exp_cnt: 8'd2, exp_found: 8'd4};
    vecs[3] = '{b: 8'h00, bl: 8'd8, pl: 8'd0, wc_en: 1'b0, pat: 32'h41000000, exp_cnt: 8'd0, exp_found: 8'd0};
    vecs[4] = '{b: 8'h20, bl: 8'd4, pl: 8'd5, wc_en: 1'b0, pat: 32'h41414141, exp_cnt: 8'd0, exp_found: 8'd0};
    vecs[5] = '{b: 8'h20, bl: 8'd4, pl: 8'd2, wc_en: 1'b0, pat: 32'h41410000, exp_cnt: 8'd3, exp_found: 8'd2};
    vecs[6] = '{b: 8'h10, bl: 8'd6, pl: 8'd3, wc_en: 1'b0, pat: 32'h413F4300, exp_cnt: 8'd0, exp_found: 8'd0};
    vecs[7] = '{b: 8'h00, bl: 8'd4, pl: 8'd4, wc_en: 1'b0, pat: 32'h41424341, exp_cnt: 8'd1, exp_found: 8'd0};

    for (int k = 0; k < 256; k++) begin
      dmem[k] = 8'h00;
      pmem[k] = 8'h00;
    end
    for (int k = 0; k < 8; k++) dmem[k] = (k % 3 == 0) ? 8'h41 : (k % 3 == 1) ? 8'h42 : 8'h43;
    dmem[8'h10] = 8'h41; dmem[8'h11] = 8'h58; dmem[8'h12] = 8'h43;
    dmem[8'h13] = 8'h41; dmem[8'h14] = 8'h59; dmem[8'h15] = 8'h43;
    for (int k = 8'h20; k < 8'h24; k++) dmem[k] = 8'h41;
    dmem[8'hFE] = 8'h61;
    dmem[8'hFF] = 8'h51;

    bus.start = 1'b0; bus.resume = 1'b0; bus.mode = MODE_FIRST;
    bus.p = '0; bus.pl = '0; bus.b = '0; bus.bl = '0; bus.wc_en = 1'b0; bus.wc_val = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_hit", 32'(bus.hit), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_found", 32'(bus.found), 32'd0);
    chk("rst_cnt", 32'(bus.match_count), 32'd0);
    chk("rst_addra", 32'(bus.addra), 32'd0);
    chk("rst_addra_p", 32'(bus.addra_p), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // First-match latency: hit at offset 0 with pl=2 takes 1+3*2 cycles.
    load_cmd(8'h00, 8'd8, 8'h40, 8'd2, MODE_FIRST, 1'b0, 32'h41420000);
    pulse(1'b1, 1'b0);
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    wait_for(1'b0, 200, n);
    chk("hit_latency", 32'(n), 32'd7);
    chk("hit0_found", 32'(bus.found), 32'd0);
    chk("hit0_busy", 32'(bus.busy), 32'd0);

    // Mode 0 "BC": hit at 1, start+resume together restarts, then resume walks on.
    load_cmd(8'h00, 8'd8, 8'h40, 8'd2, MODE_FIRST, 1'b0, 32'h42430000);
    pulse(1'b1, 1'b0);
    wait_for(1'b0, 200, n);
    chk("bc_found1", 32'(bus.found), 32'd1);
    chk("bc_cnt1", 32'(bus.match_count), 32'd1);
    pulse(1'b1, 1'b1);
    wait_for(1'b0, 200, n);
    chk("bc_restart_found", 32'(bus.found), 32'd1);
    chk("bc_restart_cnt", 32'(bus.match_count), 32'd1);
    pulse(1'b0, 1'b1);
    chk("bc_resume_busy", 32'(bus.busy), 32'd1);
    chk("bc_resume_hit", 32'(bus.hit), 32'd0);
    wait_for(1'b0, 200, n);
    chk("bc_found2", 32'(bus.found), 32'd4);
    pulse(1'b0, 1'b1);
    wait_for(1'b1, 200, n);
    chk("bc_end_cnt", 32'(bus.match_count), 32'd2);
    chk("bc_end_hit", 32'(bus.hit), 32'd0);

    // Empty pattern finishes one cycle after CHECK.
    load_cmd(8'h00, 8'd8, 8'h40, 8'd0, MODE_COUNT, 1'b0, 32'h0);
    pulse(1'b1, 1'b0);
    wait_for(1'b1, 50, n);
    chk("pl0_latency", 32'(n), 32'd1);

    // Pattern longer than block: no BRAM access at all.
    load_cmd(8'h20, 8'd4, 8'h40, 8'd5, MODE_COUNT, 1'b0, 32'h41414141);
    s = addr_n;
    pulse(1'b1, 1'b0);
    wait_for(1'b1, 50, n);
    chk("long_latency", 32'(n), 32'd1);
    chk("long_cnt", 32'(bus.match_count), 32'd0);
    chk("long_no_access", 32'(addr_n - s), 32'd0);

    for (int v = 0; v < 8; v++) run_vec(v, vecs[v]);

    // Data and pattern addresses both wrap across 8'hFF.
    load_cmd(8'hFE, 8'd4, 8'hFF, 8'd2, MODE_FIRST, 1'b0, 32'h51410000);
    s = addr_n;
    pulse(1'b1, 1'b0);
    wait_for(1'b0, 200, n);
    chk("wrap_found", 32'(bus.found), 32'd1);
    seen = 1'b0;
    for (int k = s; k + 1 < addr_n; k++) begin
      if (addr_log[k % 4096] == 8'hFF && addr_log[(k + 1) % 4096] == 8'h00) seen = 1'b1;
    end
    chk("wrap_addr_seq", 32'(seen), 32'd1);

    // Reset in CMP of the first compare, then a clean rerun.
    load_cmd(vecs[1].b, vecs[1].bl, 8'h40, vecs[1].pl, MODE_COUNT, vecs[1].wc_en, vecs[1].pat);
    pulse(1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_addra", 32'(bus.addra), 32'd0);
    chk("midrst_addra_p", 32'(bus.addra_p), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(8, vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
